// File: rtl/core_run_pkg.sv
// Purpose: shared types and constants for the core run/reset harness.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: run_state_t FSM encoding, TOHOST_PASS completion value.
package core_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  // Value a riscv-tests program writes to TOHOST to signal success.
  localparam logic [31:0] TOHOST_PASS = 32'h1;

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Latency: count reflects clear/en one cycle after the sampling edge.
// Backpressure: none; en is a plain increment qualifier.
// Ports: clk, rst (async active-low), clear (sync, wins over en), en, count[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_run_controller.sv
// Purpose: sequences rv32i_core reset, bounds run time, snoops TOHOST for a pass/fail verdict.
// Latency: verdict and done appear the cycle after the terminating RUN edge.
// Backpressure: none; start is only sampled in IDLE and DONE, snooped writes are never stalled.
// Ports: clk, rst (async active-low), start, core_rst_o, mon_we/mon_addr/mon_wdata (write snoop),
//        retire, busy, done, pass, fail, timeout, result_code, cycle_count, instret_count.
module core_run_controller
  import core_run_pkg::*;
#(
  parameter int                RESET_CYCLES       = 2,
  parameter int                TIMEOUT_CYCLES     = 30,
  parameter int                CNT_W              = 32,
  parameter int                ADDR_W             = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR        = 'h0000_1000,
  parameter bit                AUTO_START         = 1'b1,
  parameter bit                HOLD_RESET_ON_DONE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              core_rst_o,
  input  logic              mon_we,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [31:0]       mon_wdata,
  input  logic              retire,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [30:0]       result_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  // Down-counter holds RESET_CYCLES-1 on entry; RESET exits when it reaches zero.
  localparam int                RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0]  RST_LOAD = RST_W'(RESET_CYCLES - 1);
  // Watchdog fires on the edge where the pre-increment count is TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t       state, state_nxt;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic             pass_nxt, fail_nxt, timeout_nxt;
  logic [30:0]      result_nxt;
  logic             core_rst_nxt;
  logic             clear_cnt;
  logic             tohost_hit;
  logic             in_run;

  assign in_run     = (state == RUN);
  assign tohost_hit = mon_we && (mon_addr == TOHOST_ADDR);

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    pass_nxt    = pass;
    fail_nxt    = fail;
    timeout_nxt = timeout;
    result_nxt  = result_code;
    clear_cnt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start || AUTO_START) begin
          state_nxt   = RESET;
          rst_cnt_nxt = RST_LOAD;
          clear_cnt   = 1'b1;
          pass_nxt    = 1'b0;
          fail_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          result_nxt  = '0;
        end
      end
      RESET: begin
        if (rst_cnt == '0) state_nxt = RUN;
        else               rst_cnt_nxt = rst_cnt - RST_W'(1);
      end
      RUN: begin
        // TOHOST takes priority over a coincident watchdog expiry.
        if (tohost_hit) begin
          state_nxt  = DONE;
          pass_nxt   = (mon_wdata == TOHOST_PASS);
          fail_nxt   = (mon_wdata != TOHOST_PASS);
          result_nxt = mon_wdata[31:1];
        end else if (cycle_count == WD_LAST) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end
      end
      DONE: begin
        // Restart only on an explicit start; AUTO_START applies to IDLE alone.
        if (start) begin
          state_nxt   = RESET;
          rst_cnt_nxt = RST_LOAD;
          clear_cnt   = 1'b1;
          pass_nxt    = 1'b0;
          fail_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          result_nxt  = '0;
        end
      end
    endcase

    // Decoded from next state so the registered core reset changes with the state itself.
    unique case (state_nxt)
      RUN:     core_rst_nxt = 1'b0;
      DONE:    core_rst_nxt = HOLD_RESET_ON_DONE;
      default: core_rst_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      core_rst_o  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      result_code <= '0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      core_rst_o  <= core_rst_nxt;
      busy        <= (state_nxt == RESET) || (state_nxt == RUN);
      done        <= (state_nxt == DONE);
      pass        <= pass_nxt;
      fail        <= fail_nxt;
      timeout     <= timeout_nxt;
      result_code <= result_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_cnt),
    .en    (in_run),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_cnt),
    .en    (in_run && retire),
    .count (instret_count)
  );

endmodule

// File: tb/tb_core_run_controller.sv
module tb_core_run_controller;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mon_we = 1'b0;
  logic [31:0] mon_addr = 32'h0;
  logic [31:0] mon_wdata = 32'h0;
  logic        retire = 1'b0;

  logic        core_rst_o, busy, done, pass, fail, timeout;
  logic [30:0] result_code;
  logic [31:0] cycle_count, instret_count;

  logic        s_core_rst_o, s_busy, s_done, s_pass, s_fail, s_timeout;
  logic [30:0] s_result_code;
  logic [3:0]  s_cycle_count, s_instret_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_run_controller dut (
    .clk(clk), .rst(rst), .start(start), .core_rst_o(core_rst_o),
    .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata), .retire(retire),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .result_code(result_code), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  core_run_controller #(.CNT_W(4), .TIMEOUT_CYCLES(15)) dut_small (
    .clk(clk), .rst(rst), .start(1'b0), .core_rst_o(s_core_rst_o),
    .mon_we(1'b0), .mon_addr(32'h0), .mon_wdata(32'h0), .retire(1'b1),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
    .result_code(s_result_code), .cycle_count(s_cycle_count), .instret_count(s_instret_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mon_we = 1'b0; mon_addr = 32'h0; mon_wdata = 32'h0; retire = 1'b0;
  endtask

  // Reset pulse then the 3 edges (IDLE->RESET, RESET, RESET->RUN) into the first RUN cycle.
  task automatic enter_run();
    idle_inputs();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (core_rst_o !== 1'b0) begin errors++; $display("FAIL enter_run core_rst_o got %0b want 0", core_rst_o); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) step();
    checks++; if (core_rst_o !== 1'b1) begin errors++; $display("FAIL rst_core_rst got %0b want 1", core_rst_o); end
    checks++; if ({busy, done, pass, fail, timeout} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 00000", {busy, done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0 || result_code !== 31'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d/%0d want 0/0/0", cycle_count, instret_count, result_code); end
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b1 || core_rst_o !== 1'b1) begin errors++; $display("FAIL reset_cyc1 busy/core_rst got %0b/%0b want 1/1", busy, core_rst_o); end
    step();
    checks++; if (core_rst_o !== 1'b1) begin errors++; $display("FAIL reset_cyc2 core_rst got %0b want 1", core_rst_o); end
    step();
    checks++; if (core_rst_o !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd0) begin errors++; $display("FAIL run_entry core_rst/busy/cycle got %0b/%0b/%0d want 0/1/0", core_rst_o, busy, cycle_count); end
  endtask

  // Continues from the first RUN cycle left by test_reset.
  task automatic test_timeout();
    repeat (29) step();
    checks++; if (done !== 1'b0 || cycle_count !== 32'd29) begin errors++; $display("FAIL timeout_pre done/cycle got %0b/%0d want 0/29", done, cycle_count); end
    step();
    checks++; if ({done, pass, fail, timeout} !== 4'b1001) begin errors++; $display("FAIL timeout_verdict got %b want 1001", {done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd30 || instret_count !== 32'd0) begin errors++; $display("FAIL timeout_counts got %0d/%0d want 30/0", cycle_count, instret_count); end
    checks++; if (core_rst_o !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_core_rst/busy got %0b/%0b want 1/0", core_rst_o, busy); end
  endtask

  task automatic test_pass();
    enter_run();
    for (int k = 1; k <= 5; k++) begin
      mon_we = (k == 5); mon_addr = TOHOST; mon_wdata = 32'h1;
      retire = (k == 1) || (k == 3) || (k == 4);
      step();
    end
    idle_inputs();
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL pass_verdict got %b want 1100", {done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd5 || instret_count !== 32'd3) begin errors++; $display("FAIL pass_counts got %0d/%0d want 5/3", cycle_count, instret_count); end
    checks++; if (core_rst_o !== 1'b1 || result_code !== 31'd0) begin errors++; $display("FAIL pass_core_rst/result got %0b/%0d want 1/0", core_rst_o, result_code); end
    // DONE ignores further TOHOST writes and retire pulses.
    mon_we = 1'b1; mon_addr = TOHOST; mon_wdata = 32'h7; retire = 1'b1;
    repeat (3) step();
    idle_inputs();
    checks++; if ({done, pass, fail} !== 3'b110 || cycle_count !== 32'd5 || instret_count !== 32'd3) begin errors++; $display("FAIL done_frozen got %b %0d %0d want 110 5 3", {done, pass, fail}, cycle_count, instret_count); end
  endtask

  task automatic test_fail();
    enter_run();
    for (int k = 1; k <= 4; k++) begin
      start  = (k == 1);
      mon_we = (k == 2) || (k == 4);
      mon_addr = (k == 2) ? 32'h0000_1004 : TOHOST;
      mon_wdata = 32'h7;
      step();
      if (k == 3) begin
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL other_addr_ignored done/busy got %0b/%0b want 0/1", done, busy); end
      end
    end
    idle_inputs();
    checks++; if ({done, pass, fail, timeout} !== 4'b1010) begin errors++; $display("FAIL fail_verdict got %b want 1010", {done, pass, fail, timeout}); end
    checks++; if (result_code !== 31'd3 || cycle_count !== 32'd4) begin errors++; $display("FAIL fail_result/cycle got %0d/%0d want 3/4", result_code, cycle_count); end
  endtask

  task automatic test_watchdog_tie();
    enter_run();
    repeat (29) step();
    mon_we = 1'b1; mon_addr = TOHOST; mon_wdata = 32'h1;
    step();
    idle_inputs();
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL tie_verdict got %b want 1100", {done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd30) begin errors++; $display("FAIL tie_cycle got %0d want 30", cycle_count); end
  endtask

  task automatic test_async_reset();
    enter_run();
    retire = 1'b1;
    repeat (10) step();
    retire = 1'b0;
    checks++; if (cycle_count !== 32'd10 || instret_count !== 32'd10) begin errors++; $display("FAIL midrun_counts got %0d/%0d want 10/10", cycle_count, instret_count); end
    rst = 1'b0;
    #1;
    checks++; if (core_rst_o !== 1'b1 || {busy, done, pass, fail, timeout} !== 5'b0) begin errors++; $display("FAIL async_flags got %0b/%b want 1/00000", core_rst_o, {busy, done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin errors++; $display("FAIL async_counts got %0d/%0d want 0/0", cycle_count, instret_count); end
    step(); step();
    rst = 1'b1;
    repeat (3) step();
    step();
    mon_we = 1'b1; mon_addr = TOHOST; mon_wdata = 32'h1;
    step();
    idle_inputs();
    checks++; if ({done, pass} !== 2'b11 || cycle_count !== 32'd2 || instret_count !== 32'd0) begin errors++; $display("FAIL rerun got %b %0d %0d want 11 2 0", {done, pass}, cycle_count, instret_count); end
  endtask

  // Starts from the DONE/pass state left by test_async_reset.
  task automatic test_restart();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({busy, done, pass} !== 3'b100 || cycle_count !== 32'd0 || core_rst_o !== 1'b1) begin errors++; $display("FAIL restart_clear got %b %0d %0b want 100 0 1", {busy, done, pass}, cycle_count, core_rst_o); end
    step();
    checks++; if (core_rst_o !== 1'b1) begin errors++; $display("FAIL restart_reset2 got %0b want 1", core_rst_o); end
    step();
    checks++; if (core_rst_o !== 1'b0) begin errors++; $display("FAIL restart_run got %0b want 0", core_rst_o); end
    retire = 1'b1;
    step();
    retire = 1'b0; mon_we = 1'b1; mon_addr = TOHOST; mon_wdata = 32'h5;
    step();
    idle_inputs();
    checks++; if ({done, pass, fail, timeout} !== 4'b1010 || result_code !== 31'd2) begin errors++; $display("FAIL restart_verdict got %b %0d want 1010 2", {done, pass, fail, timeout}, result_code); end
    checks++; if (cycle_count !== 32'd2 || instret_count !== 32'd1) begin errors++; $display("FAIL restart_counts got %0d/%0d want 2/1", cycle_count, instret_count); end
  endtask

  task automatic test_saturate();
    enter_run();
    repeat (14) step();
    checks++; if (s_done !== 1'b0 || s_instret_count !== 4'd14) begin errors++; $display("FAIL sat_pre done/instret got %0b/%0d want 0/14", s_done, s_instret_count); end
    step();
    checks++; if ({s_done, s_timeout} !== 2'b11 || s_cycle_count !== 4'd15 || s_instret_count !== 4'd15) begin errors++; $display("FAIL sat_timeout got %b %0d %0d want 11 15 15", {s_done, s_timeout}, s_cycle_count, s_instret_count); end
    repeat (5) step();
    checks++; if (s_instret_count !== 4'd15 || s_cycle_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d/%0d want 15/15", s_instret_count, s_cycle_count); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pass();
    test_fail();
    test_watchdog_tie();
    test_async_reset();
    test_restart();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
